multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM plus ALU decoder for the multicycle RV32I core. Sits directly upstream of the ALU.
//  Decodes the instruction-register fields, sequences fetch/decode/execute/memory/writeback states,
//  and drives alucontrol and the datapath mux selects and write enables.
//  Consumes the ALU zero flag for beq.
//  Subset: lw, sw, R-type add/sub/and/or, I-type addi/andi/ori, beq, jal.
// PARAMETERS
//  None. All encodings come from riscv_ctrl_pkg.
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  synchronous, active-high reset
//  op           in   7  instr[6:0]
//  funct3       in   3  instr[14:12]
//  funct7b5     in   1  instr[30]
//  zero         in   1  ALU zero flag (combinational from the ALU)
//  pcwrite      out  1  PC register enable
//  adrsrc       out  1  memory address: 0=PC, 1=ALUOut/result
//  memwrite     out  1  data memory write enable
//  irwrite      out  1  instruction register + oldPC enable
//  resultsrc    out  2  00=ALUOut, 01=data reg, 10=ALU result
//  alusrca      out  2  00=PC, 01=oldPC, 10=rs1 reg
//  alusrcb      out  2  00=rs2 reg, 01=imm, 10=const 4
//  regwrite     out  1  register file write enable
//  immsrc       out  2  00=I, 01=S, 10=B, 11=J
//  alucontrol   out  3  000=add, 001=sub, 010=and, 011=or (bit2 always 0)
// BEHAVIOUR
//  - State register only. Outputs are Moore-decoded from state, except:
//    - pcwrite = pcupdate | (branch & zero);
//    - immsrc is decoded from op;
//    - alucontrol is decoded from aluop/op/funct.
//  - Synchronous reset: the state goes to FETCH at the first rising edge with reset=1.
//    While reset=1, pcwrite/irwrite/regwrite/memwrite are forced to 0 (combinational gating).
//    Reset mid-instruction abandons it; the next non-reset cycle is FETCH.
//  - Default for every output not listed in a state: 0. aluop defaults to 00.
//  - States, outputs and next state:
//    FETCH   : adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, resultsrc=10, pcupdate=1 -> DECODE
//    DECODE  : alusrca=01, alusrcb=01 (branch target) ->
//              lw/sw:MEMADR, R:EXECR, I:EXECI, jal:JAL, beq:BEQ, any other op: FETCH (NOP)
//    MEMADR  : alusrca=10, alusrcb=01 -> lw:MEMREAD, sw:MEMWRITE
//    MEMREAD : resultsrc=00, adrsrc=1 -> MEMWB
//    MEMWB   : resultsrc=01, regwrite=1 -> FETCH
//    MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1 -> FETCH
//    EXECR   : alusrca=10, alusrcb=00, aluop=10 -> ALUWB
//    EXECI   : alusrca=10, alusrcb=01, aluop=10 -> ALUWB
//    JAL     : alusrca=01, alusrcb=10, resultsrc=00, pcupdate=1 -> ALUWB
//    ALUWB   : resultsrc=00, regwrite=1 -> FETCH
//    BEQ     : alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1 -> FETCH
//  - ALU decode rules:
//    - aluop=00 -> add; aluop=01 -> sub.
//    - aluop=10 with funct3=000: sub if op[5]&funct7b5, else add (addi never subtracts).
//    - aluop=10 with funct3=110 -> or; funct3=111 -> and; any other funct3 -> add.
//  - Cycle counts: lw 5, sw 4, R/I 4, jal 4, beq 3, unknown op 2.
//  - immsrc decodes from op in every state; for an unknown op it is 00.
// STRUCTURE
//  - riscv_ctrl_pkg: state enum (4-bit), opcode localparams (OP_LW 0000011, OP_SW 0100011,
//    OP_R 0110011, OP_I 0010011, OP_BEQ 1100011, OP_JAL 1101111), aluop and alucontrol codes.
//  - Sub-module alu_decoder: purely combinational (aluop, op5, funct3, funct7b5 -> alucontrol).
//    The FSM and immsrc decoding stay in this module.
// TESTING
//  1. reset=1 for 2 cycles, then 0: pcwrite/irwrite=0 during reset. First cycle after reset:
//     FETCH, with irwrite=1, pcwrite=1, alusrcb=10, alucontrol=000.
//  2. op=0110011, funct3=000, funct7b5=1 (sub): FETCH, DECODE, EXECR (alucontrol=001), ALUWB (regwrite=1), FETCH.
//  3. op=0000011 (lw): 5-cycle sequence ending in MEMWB with resultsrc=01, regwrite=1.
//     memwrite stays 0 throughout.
//  4. op=1100011 (beq): in BEQ, zero=1 -> pcwrite=1; zero=0 -> pcwrite=0. alucontrol=001 in both cases.
//  5. op=0010011, funct3=000, funct7b5=1 (addi): alucontrol=000 in EXECI.
//     funct3=111 -> 010; funct3=110 -> 011.
//  6. reset asserted during MEMWRITE: memwrite=0 that cycle, FETCH next; op=1111111 -> DECODE->FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, opcode constants, aluop and alucontrol codes,
// immediate-format select codes.
package riscv_ctrl_pkg;

  // Main control FSM states (4-bit encoding).
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  // Opcodes of the supported subset.
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // aluop: what the FSM asks of the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alucontrol codes seen by the ALU.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Immediate format selects.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: maps aluop plus instruction fields to alucontrol.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: aluop (from FSM), op5 (instr[5], separates R-type from I-type),
//        funct3, funct7b5 -> alucontrol.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3)
          // instr[30] is part of the immediate for addi, so only an
          // R-type (op5=1) with funct7b5 set is a subtract.
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM + ALU decode for the multicycle RV32I core.
// Latency: lw 5 cycles, sw/R/I/jal 4, beq 3, unknown opcode 2.
// Backpressure: none; the FSM advances every cycle unless reset is high.
// Ports: clk, reset (sync, active-high); op/funct3/funct7b5 from the IR;
//        zero from the ALU; outputs are datapath selects, write enables,
//        immsrc and alucontrol.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic       regwrite,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol
);

  state_t     state_q;
  state_t     state_d;
  logic       pcupdate;
  logic       branch;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    adrsrc     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = ALUOP_ADD;
    unique case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pcupdate  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        alusrca = 2'b01;
        alusrcb = 2'b01;
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc  = 2'b01;
        regwrite_s = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        // PC <- target held in ALUOut; ALU forms oldPC+4 for the link.
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
      end
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural writes are suppressed while reset is held so an
  // abandoned instruction never commits.
  assign pcwrite  = ~reset & (pcupdate | (branch & zero));
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign memwrite = ~reset & memwrite_s;

  always_comb begin
    immsrc = IMM_I;
    unique case (op)
      OP_SW:   immsrc = IMM_S;
      OP_BEQ:  immsrc = IMM_B;
      OP_JAL:  immsrc = IMM_J;
      default: immsrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

endmodule
